// File: rtl/exec_stage_mc_if.sv
// exec_stage_mc_if: ID/EX fields into the execute stage and EX/MEM fields out of it.
// Latency: none, wires only.
// Backpressure: oStall from the stage asks the ID/EX driver to hold every input field.
interface exec_stage_mc_if #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 4
);
  logic               iValid;
  logic [4:0]         iAluOp;
  logic               iAluUseImm;
  logic [WIDTH-1:0]   iData1;
  logic [WIDTH-1:0]   iData2;
  logic [WIDTH-1:0]   iImm;
  logic [1:0]         iFwdA;
  logic [1:0]         iFwdB;
  logic [WIDTH-1:0]   iWriteBackData;
  logic               iFlush;
  logic               iAlutoReg;
  logic               iMemtoReg;
  logic               iMemRead;
  logic               iMemWrite;
  logic [RADDR_W-1:0] iDest;
  logic [RADDR_W-1:0] iSr1;
  logic               oStall;
  logic [WIDTH-1:0]   oAluOut;
  logic [WIDTH-1:0]   oData2;
  logic [2:0]         oNVZ;
  logic               oAlutoReg;
  logic               oMemtoReg;
  logic               oMemRead;
  logic               oMemWrite;
  logic               oHalt;
  logic               oIllegal;
  logic [RADDR_W-1:0] oDest;
  logic [RADDR_W-1:0] oSr1;

  modport master (
    output iValid, iAluOp, iAluUseImm, iData1, iData2, iImm, iFwdA, iFwdB,
           iWriteBackData, iFlush, iAlutoReg, iMemtoReg, iMemRead, iMemWrite, iDest, iSr1,
    input  oStall, oAluOut, oData2, oNVZ, oAlutoReg, oMemtoReg, oMemRead, oMemWrite,
           oHalt, oIllegal, oDest, oSr1
  );

  modport slave (
    input  iValid, iAluOp, iAluUseImm, iData1, iData2, iImm, iFwdA, iFwdB,
           iWriteBackData, iFlush, iAlutoReg, iMemtoReg, iMemRead, iMemWrite, iDest, iSr1,
    output oStall, oAluOut, oData2, oNVZ, oAlutoReg, oMemtoReg, oMemRead, oMemWrite,
           oHalt, oIllegal, oDest, oSr1
  );
endinterface

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with operand forwarding, ALU, NVZ flags and EX/MEM register; MUL only with EXEC_MUL_EN.
// Latency: 1 cycle for ALU ops; a multiply takes WIDTH+2 cycles from accept to result on the outputs.
// Backpressure: oStall (combinational) holds ID/EX while a multiply runs; iFlush drops it in the same cycle.
module exec_stage_mc #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  exec_stage_mc_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_AND = 5'h02;
  localparam logic [4:0] OP_OR  = 5'h03;
  localparam logic [4:0] OP_XOR = 5'h04;
  localparam logic [4:0] OP_NOP = 5'h05;
  localparam logic [4:0] OP_SLL = 5'h06;
  localparam logic [4:0] OP_SRL = 5'h07;
  localparam logic [4:0] OP_SRA = 5'h08;
  localparam logic [4:0] OP_HLT = 5'h0E;

  logic [WIDTH-1:0]   alu_q, alu_d;
  logic [WIDTH-1:0]   st_q, st_d;
  logic [2:0]         nvz_q;
  logic               a2r_q, m2r_q, mrd_q, mwr_q, hlt_q, ill_q;
  logic [RADDR_W-1:0] dest_q, sr1_q;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [SH_W-1:0]    shamt;
  logic               hlt_d, ill_d, upd_nv, upd_z, ovf_d;
  logic               stall, bubble;

  // Operand muxes: select 1 reads our own registered result, 2 the writeback bus; the immediate replaces B only.
  always_comb begin
    op_a = bus.iData1;
    st_d = bus.iData2;
    case (bus.iFwdA)
      2'd1:    op_a = alu_q;
      2'd2:    op_a = bus.iWriteBackData;
      default: ;
    endcase
    case (bus.iFwdB)
      2'd1:    st_d = alu_q;
      2'd2:    st_d = bus.iWriteBackData;
      default: ;
    endcase
    op_b = bus.iAluUseImm ? bus.iImm : st_d;
  end

  assign shamt = op_b[SH_W-1:0];

`ifdef EXEC_MUL_EN
  localparam logic [4:0] OP_MUL = 5'h10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_st_e;

  mul_st_e          mst_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [SH_W-1:0]  cnt_q;
  logic             is_mul;

  assign is_mul = (bus.iAluOp == OP_MUL);
  assign stall  = !bus.iFlush && ((mst_q == S_IDLE && bus.iValid && is_mul) || mst_q == S_RUN);

  // Shift-add multiplier: operands latched on accept, one partial product per RUN cycle, DONE hands off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_q    <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (bus.iFlush) begin
      mst_q <= S_IDLE;
    end else begin
      case (mst_q)
        S_IDLE: begin
          if (bus.iValid && is_mul) begin
            mst_q    <= S_RUN;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SH_W'(WIDTH - 1)) mst_q <= S_DONE;
        end
        default: mst_q <= S_IDLE;
      endcase
    end
  end
`else
  assign stall = 1'b0;
`endif

  // ALU result plus which flags this opcode is allowed to touch.
  always_comb begin
    alu_d  = op_a;
    hlt_d  = 1'b0;
    ill_d  = 1'b0;
    upd_nv = 1'b0;
    upd_z  = 1'b0;
    ovf_d  = 1'b0;
    case (bus.iAluOp)
      OP_ADD: begin
        alu_d  = op_a + op_b;
        upd_nv = 1'b1;
        upd_z  = 1'b1;
        ovf_d  = (op_a[MSB] == op_b[MSB]) && (alu_d[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_d  = op_a - op_b;
        upd_nv = 1'b1;
        upd_z  = 1'b1;
        ovf_d  = (op_a[MSB] != op_b[MSB]) && (alu_d[MSB] != op_a[MSB]);
      end
      OP_AND: begin alu_d = op_a & op_b;  upd_z = 1'b1; end
      OP_OR:  begin alu_d = op_a | op_b;  upd_z = 1'b1; end
      OP_XOR: begin alu_d = op_a ^ op_b;  upd_z = 1'b1; end
      OP_NOP: ;
      OP_SLL: begin alu_d = op_a << shamt; upd_z = 1'b1; end
      OP_SRL: begin alu_d = op_a >> shamt; upd_z = 1'b1; end
      OP_SRA: begin alu_d = $unsigned($signed(op_a) >>> shamt); upd_z = 1'b1; end
      OP_HLT: hlt_d = 1'b1;
`ifdef EXEC_MUL_EN
      OP_MUL: begin alu_d = acc_q; upd_z = 1'b1; end
`endif
      default: ill_d = 1'b1;
    endcase
  end

  assign bubble = !bus.iValid || bus.iFlush || stall;

  // EX/MEM register: bubbles clear controls, data holds while stalled so forwarding stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q  <= '0;
      st_q   <= '0;
      nvz_q  <= 3'b000;
      a2r_q  <= 1'b0;
      m2r_q  <= 1'b0;
      mrd_q  <= 1'b0;
      mwr_q  <= 1'b0;
      hlt_q  <= 1'b0;
      ill_q  <= 1'b0;
      dest_q <= '0;
      sr1_q  <= '0;
    end else begin
      a2r_q <= !bubble && bus.iAlutoReg;
      m2r_q <= !bubble && bus.iMemtoReg;
      mrd_q <= !bubble && bus.iMemRead;
      mwr_q <= !bubble && bus.iMemWrite;
      hlt_q <= !bubble && hlt_d;
      ill_q <= !bubble && ill_d;
      if (!stall) begin
        alu_q  <= alu_d;
        st_q   <= st_d;
        dest_q <= bus.iDest;
        sr1_q  <= bus.iSr1;
      end
      if (!bubble) begin
        if (upd_nv) nvz_q[2:1] <= {alu_d[MSB], ovf_d};
        if (upd_z)  nvz_q[0]   <= (alu_d == '0);
      end
    end
  end

  assign bus.oStall    = stall;
  assign bus.oAluOut   = alu_q;
  assign bus.oData2    = st_q;
  assign bus.oNVZ      = nvz_q;
  assign bus.oAlutoReg = a2r_q;
  assign bus.oMemtoReg = m2r_q;
  assign bus.oMemRead  = mrd_q;
  assign bus.oMemWrite = mwr_q;
  assign bus.oHalt     = hlt_q;
  assign bus.oIllegal  = ill_q;
  assign bus.oDest     = dest_q;
  assign bus.oSr1      = sr1_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc: randomized and directed stimulus for exec_stage_mc against an arithmetic reference model.
// Latency: expectations for an instruction are compared on the negedge after its capture edge.
// Backpressure: multiplies are held on the inputs for the stall window (EXEC_MUL_EN builds only).
module tb_exec_stage_mc;
  localparam int     W     = 16;
  localparam int     RW    = 4;
  localparam longint TWO_W = longint'(1) << W;
  localparam longint LMASK = TWO_W - 1;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_stage_mc_if #(.WIDTH(W), .RADDR_W(RW)) bus ();
  exec_stage_mc #(.WIDTH(W), .RADDR_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic valid, flush, use_imm, a2r, m2r, mrd, mwr;
    logic [4:0] op;
    logic [1:0] fa, fb;
    logic [W-1:0] d1, d2, imm, wb;
    logic [RW-1:0] dest, sr1;
  } ins_t;

  typedef struct {
    logic chk, dchk;
    logic a2r, m2r, mrd, mwr, hlt, ill;
    logic [W-1:0] alu, d2;
    logic [2:0] nvz;
    logic [RW-1:0] dest, sr1;
  } exp_t;

  int       total = 0;
  int       bad = 0;
  int       stall_seen = 0;
  bit       run_chk = 1'b0;
  exp_t     nxt, cur;
  logic     nxt_stall = 1'b0;
  logic [W-1:0] m_alu = '0;
  bit       m_known = 1'b1;
  logic [2:0] m_nvz = 3'b000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pick(input logic [1:0] s, input logic [W-1:0] rf, input logic [W-1:0] wb);
    if (s == 2'd1) return longint'(m_alu);
    if (s == 2'd2) return longint'(wb);
    return longint'(rf);
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '{default: '0};
    e.chk = 1'b1;
    e.nvz = m_nvz;
    return e;
  endfunction

  // Reference: what the EX/MEM register must hold after this instruction is captured.
  task automatic model(input ins_t x, output exp_t e);
    longint a, b, bs, sa, sb, r, s;
    int sh;
    bit legal, set_nv, set_z, cap;
    cap = x.valid && !x.flush;
    a  = pick(x.fa, x.d1, x.wb);
    bs = pick(x.fb, x.d2, x.wb);
    b  = x.use_imm ? longint'(x.imm) : bs;
    sa = (a >= TWO_W / 2) ? a - TWO_W : a;
    sb = (b >= TWO_W / 2) ? b - TWO_W : b;
    sh = int'(b % W);
    r = a; s = 0; legal = 1'b1; set_nv = 1'b0; set_z = 1'b0;
    case (x.op)
      5'h00: begin s = sa + sb; r = (a + b) & LMASK; set_nv = 1'b1; set_z = 1'b1; end
      5'h01: begin s = sa - sb; r = (a - b) & LMASK; set_nv = 1'b1; set_z = 1'b1; end
      5'h02: begin r = a & b; set_z = 1'b1; end
      5'h03: begin r = a | b; set_z = 1'b1; end
      5'h04: begin r = a ^ b; set_z = 1'b1; end
      5'h05: r = a;
      5'h06: begin r = (a << sh) & LMASK; set_z = 1'b1; end
      5'h07: begin r = a >> sh; set_z = 1'b1; end
      5'h08: begin r = (sa >>> sh) & LMASK; set_z = 1'b1; end
      5'h0E: r = a;
      5'h10: begin
        if (MUL_EN) begin r = (a * b) & LMASK; set_z = 1'b1; end
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    e = '{default: '0};
    e.chk  = 1'b1;
    e.dchk = cap;
    e.a2r  = cap && x.a2r;
    e.m2r  = cap && x.m2r;
    e.mrd  = cap && x.mrd;
    e.mwr  = cap && x.mwr;
    e.hlt  = cap && (x.op == 5'h0E);
    e.ill  = cap && !legal;
    e.alu  = r[W-1:0];
    e.d2   = bs[W-1:0];
    e.dest = x.dest;
    e.sr1  = x.sr1;
    if (cap) begin
      if (set_nv) begin
        m_nvz[2] = r[W-1];
        m_nvz[1] = (s > TWO_W / 2 - 1) || (s < -(TWO_W / 2));
      end
      if (set_z) m_nvz[0] = (r == 0);
      m_alu   = r[W-1:0];
      m_known = 1'b1;
    end else begin
      m_known = 1'b0;
    end
    e.nvz = m_nvz;
  endtask

  task automatic drive(input ins_t x);
    bus.iValid = x.valid;   bus.iFlush = x.flush;   bus.iAluOp = x.op;
    bus.iAluUseImm = x.use_imm;
    bus.iData1 = x.d1;      bus.iData2 = x.d2;      bus.iImm = x.imm;
    bus.iWriteBackData = x.wb;
    bus.iFwdA = x.fa;       bus.iFwdB = x.fb;
    bus.iAlutoReg = x.a2r;  bus.iMemtoReg = x.m2r;
    bus.iMemRead = x.mrd;   bus.iMemWrite = x.mwr;
    bus.iDest = x.dest;     bus.iSr1 = x.sr1;
  endtask

  // Presents one instruction at posedge+1 and returns at posedge+1 after its capture edge.
  task automatic issue(input ins_t x, input int flush_at);
    exp_t e;
    bit acc;
    drive(x);
    acc = MUL_EN && x.valid && !x.flush && (x.op == 5'h10);
    if (acc) begin
      for (int i = 0; i <= W; i++) begin
        if (i > 0 && i == flush_at) begin
          bus.iFlush = 1'b1;
          x.flush = 1'b1;
          model(x, e);
          nxt = e;
          nxt_stall = 1'b0;
          @(posedge clk); #1;
          return;
        end
        nxt = bub();
        nxt_stall = 1'b1;
        @(posedge clk); #1;
      end
    end
    model(x, e);
    nxt = e;
    nxt_stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu"},  bus.oAluOut, 0);
    check({tag, "_d2"},   bus.oData2, 0);
    check({tag, "_nvz"},  bus.oNVZ, 0);
    check({tag, "_a2r"},  bus.oAlutoReg, 0);
    check({tag, "_m2r"},  bus.oMemtoReg, 0);
    check({tag, "_mrd"},  bus.oMemRead, 0);
    check({tag, "_mwr"},  bus.oMemWrite, 0);
    check({tag, "_hlt"},  bus.oHalt, 0);
    check({tag, "_ill"},  bus.oIllegal, 0);
    check({tag, "_dest"}, bus.oDest, 0);
    check({tag, "_sr1"},  bus.oSr1, 0);
    check({tag, "_stall"}, bus.oStall, 0);
  endtask

  task automatic reset_mid(input ins_t x, input int at);
    drive(x);
    for (int i = 0; i < at; i++) begin
      nxt = bub();
      nxt_stall = 1'b1;
      @(posedge clk); #1;
    end
    nxt.chk = 1'b0;
    nxt_stall = 1'b0;
    rst_n = 1'b0;
    bus.iValid = 1'b0;
    #2;
    check_zero("midrst");
    m_alu = '0; m_known = 1'b1; m_nvz = 3'b000;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic ins_t mk(input logic [4:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2);
    ins_t x;
    x = '{default: '0};
    x.valid = 1'b1; x.op = op; x.d1 = d1; x.d2 = d2;
    x.a2r = 1'b1; x.dest = 4'h3; x.sr1 = 4'h5;
    return x;
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    int k;
    x.valid = ($urandom_range(0, 9) != 0);
    x.flush = ($urandom_range(0, 11) == 0);
    k = $urandom_range(0, 12);
    if (k <= 8)       x.op = 5'(k);
    else if (k == 9)  x.op = 5'h0E;
    else if (k == 10) x.op = 5'h10;
    else              x.op = 5'($urandom_range(0, 31));
    x.use_imm = $urandom_range(0, 1) == 1;
    x.fa = 2'($urandom_range(0, 3));
    x.fb = 2'($urandom_range(0, 3));
    if (!m_known && x.fa == 2'd1) x.fa = 2'd0;
    if (!m_known && x.fb == 2'd1) x.fb = 2'd0;
    x.d1 = rv(); x.d2 = rv(); x.imm = rv(); x.wb = rv();
    x.a2r = $urandom_range(0, 1) == 1; x.m2r = $urandom_range(0, 1) == 1;
    x.mrd = $urandom_range(0, 1) == 1; x.mwr = $urandom_range(0, 1) == 1;
    x.dest = RW'($urandom); x.sr1 = RW'($urandom);
    return x;
  endfunction

  // Shift the expectation along with the capture edge.
  always @(posedge clk) cur <= nxt;

  // Single compare process: stall for the inputs now applied, registers for the last capture.
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      if (bus.oStall === 1'b1) stall_seen++;
      check("oStall", bus.oStall, nxt_stall);
      if (cur.chk) begin
        check("oAlutoReg", bus.oAlutoReg, cur.a2r);
        check("oMemtoReg", bus.oMemtoReg, cur.m2r);
        check("oMemRead",  bus.oMemRead,  cur.mrd);
        check("oMemWrite", bus.oMemWrite, cur.mwr);
        check("oHalt",     bus.oHalt,     cur.hlt);
        check("oIllegal",  bus.oIllegal,  cur.ill);
        check("oNVZ",      bus.oNVZ,      cur.nvz);
        if (cur.dchk) begin
          check("oAluOut", bus.oAluOut, cur.alu);
          check("oData2",  bus.oData2,  cur.d2);
          check("oDest",   bus.oDest,   cur.dest);
          check("oSr1",    bus.oSr1,    cur.sr1);
        end
      end
    end
  end

  initial begin
    ins_t x;
    int   s0;
    nxt = '{default: '0};
    x = mk(5'h00, '0, '0);
    x.valid = 1'b0;
    drive(x);
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_chk = 1'b1;

    x = mk(5'h00, 16'h7FFF, 16'h0001); issue(x, -1);
    check("add_ovf_alu", bus.oAluOut, 16'h8000);
    check("add_ovf_nvz", bus.oNVZ, 3'b110);
    x = mk(5'h01, 16'd5, 16'd5); issue(x, -1);
    check("sub_zero_nvz", bus.oNVZ, 3'b001);

    x = mk(5'h00, 16'd3, 16'd4); issue(x, -1);
    check("add_3_4", bus.oAluOut, 16'd7);
    x = mk(5'h00, 16'h0, 16'd10); x.fa = 2'd1; issue(x, -1);
    check("fwd_exmem", bus.oAluOut, 16'd17);
    x.fa = 2'd2; x.wb = 16'h0020; issue(x, -1);
    check("fwd_wb", bus.oAluOut, 16'h002A);
    x = mk(5'h00, 16'd1, 16'h0099); x.use_imm = 1'b1; x.imm = 16'd5;
    x.fb = 2'd2; x.wb = 16'h0040; issue(x, -1);
    check("imm_alu", bus.oAluOut, 16'd6);
    check("imm_data2", bus.oData2, 16'h0040);

    x = mk(5'h0E, 16'h0055, '0); issue(x, -1);
    check("hlt_set", bus.oHalt, 1);
    x = mk(5'h05, 16'h0001, '0); issue(x, -1);
    check("hlt_one_cycle", bus.oHalt, 0);
    x = mk(5'h0E, 16'h0055, '0); x.flush = 1'b1; issue(x, -1);
    check("hlt_flushed", bus.oHalt, 0);
    x = mk(5'h1F, 16'h1234, '0); issue(x, -1);
    check("illegal_flag", bus.oIllegal, 1);
    check("illegal_alu", bus.oAluOut, 16'h1234);
    check("illegal_nvz", bus.oNVZ, 3'b000);

    s0 = stall_seen;
    x = mk(5'h10, 16'h0012, 16'h0034); issue(x, -1);
`ifdef EXEC_MUL_EN
    check("mul_alu", bus.oAluOut, 16'h03A8);
    check("mul_z", bus.oNVZ[0], 0);
    check("mul_stall_cycles", stall_seen - s0, W + 1);
    x = mk(5'h10, 16'h0007, 16'h0009); issue(x, 5);
    check("flush_stall", bus.oStall, 0);
    check("flush_bubble", bus.oAlutoReg, 0);
    check("flush_nvz", bus.oNVZ, 3'b000);
    x = mk(5'h00, 16'd2, 16'd2); issue(x, -1);
    check("after_flush_add", bus.oAluOut, 16'd4);
`else
    check("mul_illegal", bus.oIllegal, 1);
    check("mul_as_nop", bus.oAluOut, 16'h0012);
    check("mul_nvz_held", bus.oNVZ, 3'b000);
    check("mul_no_stall", stall_seen - s0, 0);
`endif

    x = MUL_EN ? mk(5'h10, 16'h0F0F, 16'h0003) : mk(5'h00, 16'd9, 16'd9);
    reset_mid(x, MUL_EN ? 3 : 0);
    x = mk(5'h00, 16'd1, 16'd1); issue(x, -1);
    check("post_rst_add", bus.oAluOut, 16'd2);

    for (int n = 0; n < 400; n++) begin
      x = rand_ins();
      issue(x, $urandom_range(0, 40));
    end
    @(negedge clk); #1;
    run_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
